// File: rtl/handshake_rx.sv
// rtl/handshake_rx.sv - valid/ready receiver with show-ahead FIFO and handshake stability monitor
module handshake_rx #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   input  logic [DATA_W-1:0]        s_data,
   output logic                     s_ready,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        dataout,
   output logic                     data_vld,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [CNT_W-1:0]         beat_cnt,
   output logic                     proto_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              stall_q;
   logic [DATA_W-1:0] data_q;
   logic              push;
   logic              pop;

   // s_ready depends on registered occupancy only, so a full FIFO costs one bubble after a pop
   assign s_ready  = (fill != FULL_LVL);
   assign data_vld = (fill != '0);
   assign dataout  = data_vld ? mem[rd_ptr] : '0;
   assign push     = s_valid && s_ready;
   assign pop      = rd_en && data_vld;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         beat_cnt  <= '0;
         proto_err <= 1'b0;
         stall_q   <= 1'b0;
         data_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            fill <= fill + 1'b1;
         else if (pop && !push)
            fill <= fill - 1'b1;
         // a stalled beat must stay valid with unchanged data until accepted
         stall_q <= s_valid && !s_ready;
         data_q  <= s_data;
         if (stall_q && (!s_valid || (s_data != data_q)))
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_handshake_rx.sv
// tb/tb_handshake_rx.sv - scoreboard bench for handshake_rx against a queue-based reference model
module tb_handshake_rx;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;

   logic              clk;
   logic              rst_n;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic              rd_en;
   logic [DATA_W-1:0] dataout;
   logic              data_vld;
   logic [2:0]        fill;
   logic [CNT_W-1:0]  beat_cnt;
   logic              proto_err;

   int checks   = 0;
   int failures = 0;

   handshake_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .rd_en     (rd_en),
      .dataout   (dataout),
      .data_vld  (data_vld),
      .fill      (fill),
      .beat_cnt  (beat_cnt),
      .proto_err (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: FIFO contents, accepted count, sticky error
   logic [DATA_W-1:0] mq[$];
   logic [CNT_W-1:0]  mcnt;
   logic              perr;
   logic              prev_stall;
   logic [DATA_W-1:0] prev_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         mcnt       = '0;
         perr       = 1'b0;
         prev_stall = 1'b0;
         prev_data  = '0;
      end else begin
         int n;
         n = mq.size();
         chk("s_ready",   32'(s_ready),   32'(n != DEPTH));
         chk("data_vld",  32'(data_vld),  32'(n != 0));
         chk("dataout",   dataout,        (n != 0) ? mq[0] : 32'd0);
         chk("fill",      32'(fill),      32'(n));
         chk("beat_cnt",  32'(beat_cnt),  32'(mcnt));
         chk("proto_err", 32'(proto_err), 32'(perr));
         if (prev_stall && (!s_valid || s_data != prev_data))
            perr = 1'b1;
         prev_stall = s_valid && (n == DEPTH);
         prev_data  = s_data;
         if (rd_en && n > 0)
            void'(mq.pop_front());
         if (s_valid && n < DEPTH) begin
            mq.push_back(s_data);
            mcnt = mcnt + 1'b1;
         end
      end
   end

   logic acc;

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r);
      @(posedge clk);
      #2;
      s_valid = v;
      s_data  = d;
      rd_en   = r;
      acc     = v && s_ready;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_fill",     32'(fill),      32'd0);
      chk("rst_data_vld", 32'(data_vld),  32'd0);
      chk("rst_dataout",  dataout,        32'd0);
      chk("rst_s_ready",  32'(s_ready),   32'd1);
      chk("rst_beat_cnt", 32'(beat_cnt),  32'd0);
      chk("rst_proto",    32'(proto_err), 32'd0);
      #3 rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int k = 0; k < 3 * DEPTH; k++)
         drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0);
   endtask

   initial begin
      logic              hv;
      logic [DATA_W-1:0] hd;
      int                idx;
      rst_n   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      rd_en   = 1'b0;
      acc     = 1'b0;
      #1 rst_n = 1'b0;
      do_reset();

      // single beat
      drive(1'b1, 32'd55, 1'b0);
      drive(1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0);

      // fill to full, stalled fifth beat, pop releases it
      for (int i = 0; i < 4; i++)
         drive(1'b1, 32'(66 + i), 1'b0);
      drive(1'b1, 32'd70, 1'b0);
      drive(1'b1, 32'd70, 1'b0);
      drive(1'b1, 32'd70, 1'b1);
      drive(1'b1, 32'd70, 1'b0);
      drive(1'b0, '0, 1'b0);
      chk("full_no_proto", 32'(proto_err), 32'd0);
      drain();

      // simultaneous push/pop at fill=2
      drive(1'b1, 32'd201, 1'b0);
      drive(1'b1, 32'd202, 1'b0);
      for (int i = 1; i <= 6; i++)
         drive(1'b1, 32'(i), 1'b1);
      drive(1'b0, '0, 1'b0);
      drain();

      // wrap-around from a clean count: 10 beats popped at half rate
      do_reset();
      idx = 0;
      for (int k = 0; k < 200 && idx < 10; k++) begin
         drive(1'b1, 32'(100 + idx), 1'(k % 2));
         if (acc) idx++;
      end
      drive(1'b0, '0, 1'b0);
      chk("wrap_beat_cnt", 32'(beat_cnt), 32'd10);
      drain();

      // data change while stalled
      do_reset();
      for (int i = 0; i < 4; i++)
         drive(1'b1, 32'(i), 1'b0);
      drive(1'b1, 32'd55, 1'b0);
      drive(1'b1, 32'd55, 1'b0);
      drive(1'b1, 32'd66, 1'b0);
      drive(1'b0, '0, 1'b0);
      chk("proto_data_change", 32'(proto_err), 32'd1);
      drain();
      chk("proto_sticky", 32'(proto_err), 32'd1);

      // valid dropped while stalled
      do_reset();
      for (int i = 0; i < 4; i++)
         drive(1'b1, 32'(i), 1'b0);
      drive(1'b1, 32'd77, 1'b0);
      drive(1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b0);
      chk("proto_valid_drop", 32'(proto_err), 32'd1);

      // reset mid-operation, then a fresh beat comes out first
      do_reset();
      for (int i = 0; i < 3; i++)
         drive(1'b1, 32'(300 + i), 1'b0);
      drive(1'b0, '0, 1'b0);
      chk("pre_rst_fill", 32'(fill), 32'd3);
      do_reset();
      drive(1'b1, 32'd55, 1'b0);
      drive(1'b0, '0, 1'b0);
      chk("post_rst_head", dataout, 32'd55);
      drain();

      // randomized traffic, stalled beats usually held stable
      do_reset();
      hv = 1'b0;
      hd = '0;
      for (int k = 0; k < 600; k++) begin
         if (!(hv && !acc && $urandom_range(0, 9) != 0)) begin
            hv = 1'($urandom_range(0, 2) != 0);
            hd = $urandom;
         end
         drive(hv, hd, 1'($urandom_range(0, 1)));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/handshake_rx.md
Name: handshake_rx

Overview:
- Receiving end of the team's AXI4-style valid/ready handshake; sits downstream of the `handshack` transmitter.
- Accepts 32-bit beats on `s_valid`/`s_ready` and buffers them in a small FIFO.
- Presents buffered beats to local logic as a show-ahead `dataout`/`data_vld` pair, popped with `rd_en`.
- Monitors the incoming handshake for AXI stability violations.

Parameters:
- DATA_W, 32, width of the data bus.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  transmitter asserts: `s_data` holds a valid beat.
- s_data  input  DATA_W  incoming beat.
- s_ready  output  1  receiver can accept a beat this cycle.
- rd_en  input  1  local consumer pops the head entry.
- dataout  output  DATA_W  head-of-FIFO data (show-ahead).
- data_vld  output  1  `dataout` is valid (FIFO not empty).
- fill  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- beat_cnt  output  CNT_W  total beats accepted since reset.
- proto_err  output  1  sticky flag: handshake stability violation seen.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, fill=0, beat_cnt=0, proto_err=0, stall_q=0, data_q=0.
  - Outputs then read: s_ready=1, data_vld=0, dataout=0.
  - Memory contents need not be cleared; dataout is forced to 0 while fill==0.
- s_ready = (fill != DEPTH), decoded from registered fill only. There is no combinational path from s_valid or rd_en to s_ready.
- Push: s_valid && s_ready at the rising edge.
  - Write s_data to mem[wr_ptr].
  - wr_ptr+1, wrapping modulo DEPTH.
  - beat_cnt+1, wrapping at 2^CNT_W.
- Pop: rd_en && data_vld at the rising edge → rd_ptr+1, wrapping.
  - rd_en while empty is ignored: no pointer change, no error.
- fill update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Full (fill==DEPTH): s_ready=0, so no push, even if rd_en pops in the same cycle. s_ready rises the cycle after the pop (one bubble; no bypass).
- Empty (fill==0): data_vld=0, dataout=0.
  - A pushed beat appears on dataout/data_vld in the next cycle (latency 1, no write-to-read bypass).
- data_vld = (fill != 0). dataout = mem[rd_ptr] when data_vld, else 0.
- Ordering is strict FIFO; no beat is dropped or duplicated under any push/pop interleaving.
- Protocol monitor:
  - stall_q <= s_valid && !s_ready; data_q <= s_data (every cycle).
  - If stall_q==1 and, in the current cycle, (s_valid==0 or s_data != data_q), set proto_err=1.
  - proto_err stays set until rst_n asserts; it does not block data flow.
- Reset mid-transfer: all state returns to reset values immediately on rst_n low.
  - Buffered beats are discarded.
  - s_ready returns to 1 asynchronously (fill=0).
- Wrap-around: both pointers wrap cleanly. Full/empty is decided by fill, not by pointer comparison.

Test Plan:
1. Single beat:
   - Stimulus: release reset; s_data=55, s_valid=1 for one cycle with s_ready=1.
   - Required: next cycle data_vld=1, dataout=55, fill=1, beat_cnt=1.
   - Then rd_en=1 for one cycle → data_vld=0, dataout=0, fill=0.
2. Fill to full:
   - Stimulus: push 66,67,68,69 back-to-back, no rd_en.
   - Required: fill=4, s_ready=0. A fifth beat (70) is held with s_valid=1 and stable data. No push occurs; proto_err stays 0.
   - Then pop once → dataout changes 66→67, and s_ready=1 one cycle after the pop.
   - Beat 70 is accepted on the following edge; subsequent pops yield 67,68,69,70.
3. Simultaneous push/pop:
   - Stimulus: with fill=2, assert s_valid and rd_en together for 6 cycles with values 1..6.
   - Required: fill stays 2 throughout; output order continues correctly; beat_cnt increases by 6.
4. Wrap-around:
   - Stimulus: stream 10 beats (100..109) while popping at half rate.
   - Required: all 10 values emerge in order; pointers wrap with no loss; beat_cnt=10.
5. Protocol violation:
   - Stimulus: hold FIFO full, drive s_valid=1, s_data=55, then change s_data to 66 while s_ready=0.
   - Required: proto_err=1 the same cycle and remains 1. A separate run that drops s_valid while stalled also sets proto_err.
6. Reset mid-operation:
   - Stimulus: with fill=3 and beat_cnt=3, pulse rst_n low asynchronously, between clock edges.
   - Required: fill=0, data_vld=0, dataout=0, s_ready=1, beat_cnt=0, proto_err=0 immediately, without waiting for a clock edge.
   - Next push of 55 is output as the first beat.
